// File: rtl/mult_div_unit_pkg.sv
// Shared op/state encodings and decode helpers for the iterative multiply/divide unit.
// Signed decoding is only consumed when MDU_SIGNED_EN is defined.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_DIVU  = 2'b01,
        OP_MULT  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX-stage operand muxes and the multiply/divide unit.
// master drives operands and MTHI/MTLO writes; slave returns busy/done and HI/LO.
interface mult_div_unit_if
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             start;
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, wr_hi, wr_lo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, wr_hi, wr_lo, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mult_div_unit_step.sv
// One iteration of the multiply/divide datapath: shift-add (mode=0) or restoring
// shift-subtract (mode=1) on a 2*WIDTH accumulator.
module mult_div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;

    always_comb begin
        // Multiply: upper half accumulates the multiplicand, carry shifts in from the top.
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Divide: partial remainder picks up the next dividend bit before the trial subtract.
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, operand};
        rem_diff  = rem_shift[WIDTH-1:0] - operand;

        if (mode) begin
            if (rem_ge) begin
                acc_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Define MDU_SIGNED_EN to build signed ops (magnitude entry plus a one-cycle FIX sign correction).
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   operand_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               is_div_reg;
    logic               busy_reg;
    logic               done_reg;

    logic               accept;
    logic               op_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // A flush in IDLE also swallows a start presented in the same cycle.
    assign accept = (state_reg == ST_IDLE) && bus.start && !bus.flush;
    assign op_div = op_is_div(bus.op);

`ifdef MDU_SIGNED_EN
    logic               op_sgn;
    logic               a_neg;
    logic               b_neg;
    logic               sgn_reg;
    logic               neg_prod_reg;
    logic               neg_lo_reg;
    logic               neg_hi_reg;
    logic [2*WIDTH-1:0] fix_result;

    assign op_sgn = op_is_signed(bus.op);
    assign a_neg  = op_sgn && bus.a[WIDTH-1];
    assign b_neg  = op_sgn && bus.b[WIDTH-1];
    assign a_mag  = a_neg ? -bus.a : bus.a;
    assign b_mag  = b_neg ? -bus.b : bus.b;

    always_comb begin
        fix_result = acc_reg;
        if (!is_div_reg) begin
            if (neg_prod_reg) begin
                fix_result = -acc_reg;
            end
        end else begin
            if (neg_hi_reg) begin
                fix_result[2*WIDTH-1:WIDTH] = -acc_reg[2*WIDTH-1:WIDTH];
            end
            if (neg_lo_reg) begin
                fix_result[WIDTH-1:0] = -acc_reg[WIDTH-1:0];
            end
        end
    end
`else
    assign a_mag = bus.a;
    assign b_mag = bus.b;
`endif

    mult_div_unit_step #(
        .WIDTH (WIDTH)
    ) u_mdu_step (
        .acc      (acc_reg),
        .operand  (operand_reg),
        .mode     (is_div_reg),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            acc_reg      <= '0;
            operand_reg  <= '0;
            is_div_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
`ifdef MDU_SIGNED_EN
            sgn_reg      <= 1'b0;
            neg_prod_reg <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // MTHI/MTLO land before a same-cycle start; the result overwrites them later.
                    if (bus.wr_hi) begin
                        hi_reg <= bus.wdata;
                    end
                    if (bus.wr_lo) begin
                        lo_reg <= bus.wdata;
                    end
                    if (accept) begin
                        state_reg   <= ST_CALC;
                        busy_reg    <= 1'b1;
                        cnt_reg     <= '0;
                        is_div_reg  <= op_div;
                        acc_reg     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        operand_reg <= op_div ? b_mag : a_mag;
`ifdef MDU_SIGNED_EN
                        sgn_reg      <= op_sgn;
                        neg_prod_reg <= a_neg ^ b_neg;
                        // Divide-by-zero keeps an all-ones quotient regardless of sign.
                        neg_lo_reg   <= (a_neg ^ b_neg) && (bus.b != '0);
                        neg_hi_reg   <= a_neg;
`endif
                    end
                end

                ST_CALC: begin
                    if (bus.flush) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_CNT) begin
`ifdef MDU_SIGNED_EN
                            if (sgn_reg) begin
                                state_reg <= ST_FIX;
                            end else begin
                                state_reg <= ST_IDLE;
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                hi_reg    <= acc_next[2*WIDTH-1:WIDTH];
                                lo_reg    <= acc_next[WIDTH-1:0];
                            end
`else
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            hi_reg    <= acc_next[2*WIDTH-1:WIDTH];
                            lo_reg    <= acc_next[WIDTH-1:0];
`endif
                        end
                    end
                end

`ifdef MDU_SIGNED_EN
                ST_FIX: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    if (!bus.flush) begin
                        done_reg <= 1'b1;
                        hi_reg   <= fix_result[2*WIDTH-1:WIDTH];
                        lo_reg   <= fix_result[WIDTH-1:0];
                    end
                end
`endif

                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table plus hand sequences for flush,
// busy-time starts/writes, MTHI/MTLO ordering and asynchronous reset.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W = 32;
`ifdef MDU_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    typedef struct {
        op_e          op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model built on the simulator's own arithmetic operators.
    function automatic void model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        logic           sgn;
        logic [2*W-1:0] p;
        sgn = SIGNED_BUILD && (op == OP_MULT || op == OP_DIV);
        hi  = '0;
        lo  = '0;
        if (op == OP_MULTU || op == OP_MULT) begin
            if (sgn) p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
            else     p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            hi = p[2*W-1:W];
            lo = p[W-1:0];
        end else if (b == '0) begin
            lo = '1;
            hi = a;
        end else if (sgn && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            lo = a;
            hi = '0;
        end else if (sgn) begin
            lo = $signed(a) / $signed(b);
            hi = $signed(a) % $signed(b);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    function automatic int exp_busy_of(input op_e op);
        return (SIGNED_BUILD && (op == OP_MULT || op == OP_DIV)) ? W + 1 : W;
    endfunction

    // Called at a negedge; presents start for one cycle and returns at the next negedge.
    task automatic issue(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, checks latency when exp_busy>0, scores HI/LO and the pulse width.
    task automatic wait_done(input string name, input int exp_busy);
        int   busy_cnt;
        int   lat;
        bit   got;
        exp_t e;
        busy_cnt = 0;
        lat      = 1;
        got      = 1'b0;
        while (!got && lat < 200) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk({name, "_done_seen"}, 64'(got), 64'd1);
        if (got) begin
            if (exp_busy > 0) begin
                chk({name, "_latency"}, 64'(lat), 64'(exp_busy + 1));
                chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
            end
            if (sb_q.size() == 0) begin
                chk({name, "_sb_size"}, 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_hi"}, bus.hi, e.hi);
                chk({e.name, "_lo"}, bus.lo, e.lo);
                $display("op %-16s hi=%h lo=%h lat=%0d", e.name, bus.hi, bus.lo, lat);
            end
            @(negedge clk);
            chk({name, "_done_pulse"}, bus.done, 1'b0);
        end
    endtask

    task automatic run_op(input vec_t v);
        sb_q.push_back('{v.hi, v.lo, v.name});
        issue(v.op, v.a, v.b);
        wait_done(v.name, exp_busy_of(v.op));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int   n;

        bus.start = 1'b0;
        bus.op    = OP_MULTU;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        bus.wdata = '0;
        rst_n     = 1'b0;

        vecs.push_back('{OP_MULTU, 32'd7,          32'd6,          32'd0,          32'd42,         "multu_7x6"});
        vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  "multu_max"});
        vecs.push_back('{OP_DIVU,  32'd100,        32'd7,          32'd2,          32'd14,         "divu_100_7"});
        vecs.push_back('{OP_DIVU,  32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  "divu_by_zero"});
        vecs.push_back('{OP_DIVU,  32'd3,          32'd9,          32'd3,          32'd0,          "divu_small"});
`ifdef MDU_SIGNED_EN
        vecs.push_back('{OP_MULT,  32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  "mult_m3x5"});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  "div_m7_2"});
        vecs.push_back('{OP_DIV,   32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  "div_7_m2"});
        vecs.push_back('{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  "div_overflow"});
        vecs.push_back('{OP_MULT,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  32'd0,          "mult_min_sq"});
`else
        vecs.push_back('{OP_MULT,  32'hFFFF_FFFD,  32'd5,          32'd4,          32'hFFFF_FFF1,  "mult_as_unsigned"});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9,  32'd2,          32'd1,          32'h7FFF_FFFC,  "div_as_unsigned"});
`endif
        for (int i = 0; i < 4; i++) begin
            v.op   = op_e'(i % 4);
            v.a    = $urandom;
            v.b    = (i % 2 == 1) ? 32'($urandom_range(1, 5000)) : $urandom;
            v.name = $sformatf("rand_%0d", i);
            model(v.op, v.a, v.b, v.hi, v.lo);
            vecs.push_back(v);
        end

        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_hi", bus.hi, '0);
        chk("rst_lo", bus.lo, '0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i]);
        end

        // MTHI+MTLO together, then an MTHI coinciding with start.
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'hCAFE_0001;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        chk("mt_both_hi", bus.hi, 32'hCAFE_0001);
        chk("mt_both_lo", bus.lo, 32'hCAFE_0001);
        bus.wr_hi = 1'b1;
        bus.wdata = 32'h0000_1234;
        sb_q.push_back('{32'd0, 32'd42, "mt_with_start"});
        issue(OP_MULTU, 32'd7, 32'd6);
        bus.wr_hi = 1'b0;
        chk("mt_start_hi_first", bus.hi, 32'h0000_1234);
        chk("mt_start_lo_kept", bus.lo, 32'hCAFE_0001);
        chk("mt_start_busy", bus.busy, 1'b1);
        wait_done("mt_with_start", W);

        // Start and MTHI/MTLO during busy are dropped.
        sb_q.push_back('{32'd0, 32'd9, "busy_ignore"});
        issue(OP_MULTU, 32'd3, 32'd3);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.wr_hi = 1'b1;
        bus.wr_lo = 1'b1;
        bus.wdata = 32'h55;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        chk("busy_mthi_ignored", bus.hi, 32'd0);
        chk("busy_mtlo_ignored", bus.lo, 32'd42);
        wait_done("busy_ignore", 0);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        chk("no_queued_done", 64'(n), 64'd0);
        chk("idle_after_ignore", bus.busy, 1'b0);

        // Flush ten cycles into a DIVU.
        bus.wr_hi = 1'b1;
        bus.wdata = 32'hAA;
        @(negedge clk);
        bus.wr_hi = 1'b0;
        chk("mthi_aa", bus.hi, 32'hAA);
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", bus.busy, 1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 1'b0);
        chk("flush_hi", bus.hi, 32'hAA);
        chk("flush_lo", bus.lo, 32'd9);
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        chk("flush_no_done", 64'(n), 64'd0);

        // Flush in IDLE suppresses a same-cycle start.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd7;
        bus.b     = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("idle_flush_busy", bus.busy, 1'b0);
        @(negedge clk);
        chk("idle_flush_busy2", bus.busy, 1'b0);

        // Asynchronous reset mid-CALC.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_hi", bus.hi, '0);
        chk("arst_lo", bus.lo, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_still_idle", bus.busy, 1'b0);
        run_op('{OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "post_reset"});

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
